uart_core_param: RTL and testbench
==================================

# uart_core_param

Parametrised full-duplex UART core that replaces the fixed 8-bit transmitter/receiver pair. It supports configurable data width, parity mode and stop-bit count, with a valid/ready transmit handshake and a mid-bit-sampling receiver. All logic runs on the system clock using clock-enable bit counters; no derived clocks are generated. It sits between the register/bus side and the serial pins.

## Interface
- CLK_FREQ, 1000000, system clock frequency in Hz
- BAUD_RATE, 9600, bit rate; CPB = CLK_FREQ/BAUD_RATE (integer divide), must be ≥ 4
- DATA_BITS, 8, payload width, legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- tx_data  in  DATA_BITS  payload to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  core can accept a word
- tx_done  out  1  one-cycle pulse when a frame finishes
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous
- rx_data  out  DATA_BITS  last received payload, held until the next frame
- rx_valid  out  1  one-cycle pulse when rx_data is updated
- rx_parity_err  out  1  parity mismatch for the current rx_data (0 when PARITY = 0)
- rx_frame_err  out  1  a stop bit was sampled low for the current rx_data

## Operation
- Frame format: start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY ≠ 0, then STOP_BITS stop bits (1). Each bit lasts CPB cycles.
- Even parity: the bit equals the XOR of the data bits. Odd parity: the inverse of that XOR.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready = 1. When tx_valid && tx_ready, the core latches tx_data and moves to START.
  - Each state holds tx for CPB cycles. A bit index steps through DATA. PARITY is skipped when PARITY = 0. STOP lasts STOP_BITS × CPB cycles.
  - After STOP, the core returns to IDLE and pulses tx_done there.
  - tx_data changes while busy are ignored.
- RX path: rx passes through a 2-flop synchroniser. RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised 0 moves the FSM to START.
  - START: after CPB/2 cycles the line is resampled. If it is 1 (false start), the FSM returns to IDLE with no output.
  - Subsequent samples are taken every CPB cycles, at bit centres.
  - At the centre of the last stop bit, the core updates rx_data, rx_parity_err and rx_frame_err and pulses rx_valid.
  - rx_frame_err = 1 if any stop-bit sample is 0.
  - The FSM returns to IDLE immediately after that sample, so a start bit that arrives within half a bit is still caught.
- DATA_BITS = 9 with PARITY ≠ 0 is legal (11-bit-plus frames).
- There is no receive backpressure. A new frame overwrites rx_data.

## Timing
- Reset values: tx = 1, tx_ready = 1, tx_done = 0, rx_data = 0, rx_valid = 0, rx_parity_err = 0, rx_frame_err = 0. Both FSMs go to IDLE and all counters clear.
- Reset asserted mid-frame aborts both directions. tx reads 1 on the cycle after the reset edge. No tx_done or rx_valid pulse is produced for the aborted frame.
- TX:
  - Word accepted at edge N: tx_ready = 0 and tx = 0 from cycle N+1.
  - The frame occupies NB × CPB cycles, where NB = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS.
  - tx_done and tx_ready are both 1 in cycle N+1+NB×CPB.
  - If tx_valid is held, the next word is accepted in that same cycle, so the frame pitch is NB×CPB + 1 cycles.
- RX:
  - Latency from the line's centre of the last stop bit to rx_valid is 3 cycles (2 for the synchroniser, 1 to register).
  - rx_valid is exactly 1 cycle wide.
- TX and RX are fully independent. Simultaneous accept and receive completion are both honoured in the same cycle.

## Configuration
- UART_CORE_LOOPBACK_EN defined:
  - Adds input port loopback (1 bit), placed after rx.
  - When loopback = 1, the receiver synchroniser input is the internal tx signal, and the tx pin is forced to 1.
  - When loopback = 0, behaviour is identical to the build without the macro.
  - loopback is assumed static; changing it mid-frame yields undefined receive data but must not hang either FSM.
- Not defined: the port is absent and rx always comes from the pin.

## Test plan
- Use CLK_FREQ = 1000000, BAUD_RATE = 100000 (CPB = 10) throughout.
- 8N1, send 0xA5 -> tx pin pattern 0,1,0,1,0,0,1,0,1,1 at 10 cycles per bit; tx_done is asserted 101 cycles after accept.
- 8E1 loopback (tx wired to rx, or via the macro), send 0x37 -> rx_valid once, rx_data = 0x37, parity bit = 1, both error flags 0.
- 7O2, an external frame with a corrupted parity bit for 0x41 -> rx_data = 0x41, rx_parity_err = 1. Then a frame with its second stop bit low -> rx_frame_err = 1.
- RX glitch: 3-cycle low pulse on rx -> no rx_valid, FSM back in IDLE; a following valid frame 0x5A is received correctly.
- tx_valid held high for 3 words 0x01, 0x02, 0x03 -> three frames at a 101-cycle pitch and three tx_done pulses.
- Assert rst at cycle 45 of a frame -> tx = 1 next cycle, tx_ready = 1, no tx_done pulse; the next word transmits cleanly.

Source files
------------

// File: rtl/uart_core_param_if.sv
// uart_core_param_if: bus-side signals of the parametrised UART core.
// Handshake: a word transfers on the rising edge where tx_valid && tx_ready.
// The core raises tx_ready only when idle. It has no receive backpressure:
// rx_valid is a one-cycle strobe and is never stalled.
// tx_state / rx_state expose the two FSM encodings for observation.
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic [2:0]           tx_state;
    logic [2:0]           rx_state;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err,
        input  tx_state, rx_state
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err,
        output tx_state, rx_state
    );
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with configurable data width, parity and
// stop bits. Bit timing comes from clock-enable counters on clk; no derived
// clocks. Optional macro UART_CORE_LOOPBACK_EN adds a 'loopback' input that
// routes the internal tx into the receiver and parks the tx pin high.
module uart_core_param #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    uart_core_param_if.slave   bus,
    output logic               tx,
    input  logic               rx
`ifdef UART_CORE_LOOPBACK_EN
    ,
    input  logic               loopback
`endif
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CPB / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam bit               HAS_PAR   = (PARITY != 0);
    localparam logic             ODD       = (PARITY == 2);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [3:0]           tx_bit;
    logic                 tx_stop;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic                 tx_q;
    logic                 tx_done_q;

    // TX FSM: tx_q is registered so the pin never glitches between bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_stop   <= 1'b0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (bus.tx_valid) begin
                        tx_sh    <= bus.tx_data;
                        tx_par   <= (^bus.tx_data) ^ ODD;
                        tx_q     <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_q     <= tx_sh[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == DATA_LAST) begin
                            if (HAS_PAR) begin
                                tx_q     <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                tx_q     <= 1'b1;
                                tx_stop  <= 1'b0;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_q   <= tx_sh[1];
                            tx_sh  <= tx_sh >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_q     <= 1'b1;
                        tx_stop  <= 1'b0;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_stop == STOP_LAST) begin
                            tx_state  <= S_IDLE;
                            tx_done_q <= 1'b1;
                        end else begin
                            tx_stop <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_ready = (tx_state == S_IDLE);
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_state = tx_state;

    // ---------------- line routing ----------------
    logic rx_in;
`ifdef UART_CORE_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    assign rx_in = rx;
    assign tx    = tx_q;
`endif

    // ---------------- receiver ----------------
    logic                 rx_s1, rx_s2;
    logic [2:0]           rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [3:0]           rx_bit;
    logic                 rx_stop;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par_err;
    logic                 rx_stop_err;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q;

    // Two-flop synchroniser; resets to the idle level so reset cannot look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
        end
    end

    // RX FSM: start bit confirmed at its centre, then one sample every CPB cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_stop     <= 1'b0;
            rx_sh       <= '0;
            rx_par_err  <= 1'b0;
            rx_stop_err <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_ferr_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    // The detect cycle counts as the first cycle of the start bit.
                    if (!rx_s2) begin
                        rx_cnt   <= CNT_ONE;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_BIT) begin
                        rx_cnt      <= '0;
                        rx_bit      <= '0;
                        rx_par_err  <= 1'b0;
                        rx_stop_err <= 1'b0;
                        rx_state    <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_stop  <= 1'b0;
                            rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 4'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_err <= rx_s2 ^ (^rx_sh) ^ ODD;
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_stop == STOP_LAST) begin
                            rx_data_q  <= rx_sh;
                            rx_perr_q  <= rx_par_err;
                            rx_ferr_q  <= rx_stop_err | ~rx_s2;
                            rx_valid_q <= 1'b1;
                            rx_state   <= S_IDLE;
                        end else begin
                            rx_stop_err <= ~rx_s2;
                            rx_stop     <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_state      = rx_state;
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: three cores at CPB = 10 (8N1, 8E1 looped tx->rx, 7O2).
// Stimulus pushes expected results into queues; monitors pop and compare.
module tb_uart_core_param;
    localparam int CF  = 1000000;
    localparam int BR  = 100000;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic rx8 = 1'b1;
    logic rx7 = 1'b1;
    wire  tx8n1, tx8e1, tx7o2;

    logic [10:0] exp_rx8n1_q[$];
    logic [10:0] exp_rx8e1_q[$];
    logic [10:0] exp_rx7o2_q[$];
    logic [7:0]  exp_tx_q[$];
    int          exp_done_q[$];

    uart_core_param_if #(.DATA_BITS(8)) b8n1 ();
    uart_core_param_if #(.DATA_BITS(8)) b8e1 ();
    uart_core_param_if #(.DATA_BITS(7)) b7o2 ();

    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
        .clk(clk), .rst(rst), .bus(b8n1), .tx(tx8n1), .rx(rx8)
`ifdef UART_CORE_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );
    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u8e1 (
        .clk(clk), .rst(rst), .bus(b8e1), .tx(tx8e1), .rx(tx8e1)
`ifdef UART_CORE_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );
    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u7o2 (
        .clk(clk), .rst(rst), .bus(b7o2), .tx(tx7o2), .rx(rx7)
`ifdef UART_CORE_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pending();
        return exp_rx8n1_q.size() + exp_rx8e1_q.size() + exp_rx7o2_q.size()
             + exp_tx_q.size() + exp_done_q.size();
    endfunction

    task automatic wait_idle(input int limit);
        int n = 0;
        while (pending() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", pending(), 0);
    endtask

    task automatic wait_ready8(input logic lvl, input int limit);
        int n = 0;
        while (b8n1.tx_ready !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", b8n1.tx_ready, lvl);
    endtask

    // Send one word on the 8N1 core; returns at the first negedge of its start bit.
    task automatic send8(input logic [7:0] d, input bit push, output int acc);
        @(negedge clk);
        b8n1.tx_data  = d;
        b8n1.tx_valid = 1'b1;
        wait_ready8(1'b0, 20);
        acc = cyc;
        b8n1.tx_valid = 1'b0;
        if (push) begin
            exp_done_q.push_back(acc + 100);
            exp_tx_q.push_back(d);
        end
    endtask

    // Drive a frame bit-serially on an external rx line, LSB first.
    task automatic drive_rx(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx8 = bits[i];
            else          rx7 = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx8 = 1'b1;
        rx7 = 1'b1;
    endtask

    // RX scoreboard monitors: {frame_err, parity_err, data[8:0]}
    always @(negedge clk) begin
        if (b8n1.rx_valid) begin
            if (exp_rx8n1_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx8n1_unexpected: got rx_valid data %0h expected no frame", b8n1.rx_data);
            end else
                chk("rx8n1", {b8n1.rx_frame_err, b8n1.rx_parity_err, 1'b0, b8n1.rx_data}, exp_rx8n1_q.pop_front());
        end
        if (b8e1.rx_valid) begin
            if (exp_rx8e1_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx8e1_unexpected: got rx_valid data %0h expected no frame", b8e1.rx_data);
            end else
                chk("rx8e1", {b8e1.rx_frame_err, b8e1.rx_parity_err, 1'b0, b8e1.rx_data}, exp_rx8e1_q.pop_front());
        end
        if (b7o2.rx_valid) begin
            if (exp_rx7o2_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx7o2_unexpected: got rx_valid data %0h expected no frame", b7o2.rx_data);
            end else
                chk("rx7o2", {b7o2.rx_frame_err, b7o2.rx_parity_err, 2'b00, b7o2.rx_data}, exp_rx7o2_q.pop_front());
        end
    end

    // tx_done monitor for the 8N1 core: cycle of the pulse and tx_ready alongside
    always @(negedge clk) begin
        if (b8n1.tx_done) begin
            if (exp_done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_done_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                chk("tx_done_cycle", cyc, exp_done_q.pop_front());
                chk("tx_ready_at_done", b8n1.tx_ready, 1'b1);
            end
        end
    end

    // tx pin decoder for the 8N1 core: samples bit centres, ignores frames cut by reset
    initial begin
        logic       prev;
        logic       ab;
        logic [9:0] fr;
        logic [9:0] ex;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx8n1 && !rst) begin
                fr = '0;
                ab = 1'b0;
                for (int k = 1; k <= 95; k++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                    if (k % 10 == 5) fr[(k - 5) / 10] = tx8n1;
                end
                if (!ab) begin
                    if (exp_tx_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tx_frame_unexpected: got frame %0h expected none", fr);
                    end else begin
                        d  = exp_tx_q.pop_front();
                        ex = {1'b1, d, 1'b0};
                        chk("tx_frame", fr, ex);
                    end
                end
            end
            prev = tx8n1;
        end
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded 40000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        logic [9:0]  pat_a5;
        b8n1.tx_valid = 1'b0; b8n1.tx_data = '0;
        b8e1.tx_valid = 1'b0; b8e1.tx_data = '0;
        b7o2.tx_valid = 1'b0; b7o2.tx_data = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", tx8n1, 1'b1);
        chk("rst_tx_ready", b8n1.tx_ready, 1'b1);
        chk("rst_tx_done", b8n1.tx_done, 1'b0);
        chk("rst_rx_data", b8n1.rx_data, 8'h00);
        chk("rst_rx_valid", b8n1.rx_valid, 1'b0);
        chk("rst_perr", b7o2.rx_parity_err, 1'b0);
        chk("rst_ferr", b7o2.rx_frame_err, 1'b0);
        chk("rst_tx_state", b8n1.tx_state, 3'd0);
        chk("rst_rx_state", b8n1.rx_state, 3'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: pin pattern at bit centres, tx_done 101 cycles after accept
        pat_a5 = 10'b1101001010;
        send8(8'hA5, 1'b1, acc);
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 5 : 10) @(negedge clk);
            chk($sformatf("a5_bit%0d", i), tx8n1, pat_a5[i]);
        end
        wait_idle(200);

        // 8E1 loopback 0x37: parity bit on the wire is 1, clean reception
        @(negedge clk);
        b8e1.tx_data  = 8'h37;
        b8e1.tx_valid = 1'b1;
        exp_rx8e1_q.push_back({2'b00, 9'h037});
        @(negedge clk);
        b8e1.tx_valid = 1'b0;
        chk("e1_start", tx8e1, 1'b0);
        repeat (95) @(negedge clk);
        chk("e1_parity_bit", tx8e1, 1'b1);
        wait_idle(200);

        // 7O2: bad parity bit for 0x41, then second stop bit low
        exp_rx7o2_q.push_back({1'b0, 1'b1, 9'h041});
        drive_rx(1, {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11);
        wait_idle(50);
        repeat (20) @(negedge clk);
        exp_rx7o2_q.push_back({1'b1, 1'b0, 9'h041});
        drive_rx(1, {5'b0, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
        wait_idle(50);
        repeat (30) @(negedge clk);
        chk("o2_rx_state_idle", b7o2.rx_state, 3'd0);

        // glitch on 8N1 rx: no output, back to IDLE, then a good 0x5A frame
        rx8 = 1'b0;
        repeat (3) @(negedge clk);
        rx8 = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch_rx_state_idle", b8n1.rx_state, 3'd0);
        exp_rx8n1_q.push_back({2'b00, 9'h05A});
        drive_rx(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        wait_idle(50);

        // tx_valid held for 0x01, 0x02, 0x03: 101-cycle pitch
        @(negedge clk);
        b8n1.tx_data  = 8'h01;
        b8n1.tx_valid = 1'b1;
        wait_ready8(1'b0, 20);
        acc = cyc;
        exp_done_q.push_back(acc + 100);
        exp_done_q.push_back(acc + 201);
        exp_done_q.push_back(acc + 302);
        exp_tx_q.push_back(8'h01);
        exp_tx_q.push_back(8'h02);
        exp_tx_q.push_back(8'h03);
        b8n1.tx_data = 8'h02;
        wait_ready8(1'b1, 150);
        @(negedge clk);
        b8n1.tx_data = 8'h03;
        wait_ready8(1'b1, 150);
        @(negedge clk);
        b8n1.tx_valid = 1'b0;
        wait_idle(200);

        // reset at cycle 45 of a frame: tx high next cycle, no tx_done, then clean frame
        send8(8'h99, 1'b0, acc);
        repeat (44) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx_high", tx8n1, 1'b1);
        chk("abort_tx_ready", b8n1.tx_ready, 1'b1);
        chk("abort_tx_done", b8n1.tx_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        send8(8'h3C, 1'b1, acc);
        wait_idle(200);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
